// File: rtl/booth8_seq_ctrl.sv
// Radix-8 Booth multiplier sequencer: accepts (x,a), strobes the external forming logic,
// accumulates N signed digit multiples with 3-bit arithmetic shifts, returns the 2K-bit product.
//  state  | meaning
//  S_IDLE | ready for operands, fl_start follows in_valid
//  S_RUN  | one digit multiple accumulated per cycle, N cycles
//  S_DONE | product valid, held until out_ready
module booth8_seq_ctrl #(
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   x,
    input  logic [K-1:0]   a,
    output logic           fl_start,
    output logic [K-1:0]   fl_x,
    output logic [K-1:0]   fl_a,
    input  logic [K+2:0]   srcA,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*K-1:0] product,
    output logic           busy
);
    localparam int N  = (K + 2) / 3;
    localparam int CW = $clog2(N + 1);
    localparam int HW = K + 4;
    localparam int LW = 3 * N;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic signed [HW-1:0]  h;
    logic [LW-1:0]         l;
    logic signed [HW-1:0]  s;
    logic signed [HW-1:0]  h_nx;
    logic [LW+2:0]         l_ext;
    logic [LW-1:0]         l_nx;
    logic [HW+LW-1:0]      hl_nx;
    logic                  last_digit;

    assign fl_x = x;
    assign fl_a = a;

    // Shifted-out sum bits enter L from the top; generic for N=1 as well.
    always_comb begin
        s          = h + {srcA[K+2], srcA};
        h_nx       = s >>> 3;
        l_ext      = {s[2:0], l};
        l_nx       = l_ext[LW+2:3];
        hl_nx      = {h_nx, l_nx};
        last_digit = (cnt == CW'(N - 1));
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        fl_start = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                fl_start = in_valid;
                if (in_valid) state_nx = S_RUN;
            end
            S_RUN: begin
                if (last_digit) state_nx = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            h         <= '0;
            l         <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        h   <= '0;
                        l   <= '0;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    h   <= h_nx;
                    l   <= l_nx;
                    cnt <= cnt + CW'(1);
                    if (last_digit) begin
                        product   <= hl_nx[2*K-1:0];
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
